// File: rtl/vertex_criterion_demux_arbiter.sv
// Round-robin arbiter feeding a selector-keyed demux with per-bus credits.
// Selector constants live in globals_cu_pkg, declared alongside the arbiter.
package globals_cu_pkg;
  localparam logic [31:0] VERTEX_VALUE_HOT_U32      = 32'h0000_0011;
  localparam logic [31:0] VERTEX_CACHE_WARM_U32     = 32'h0000_0022;
  localparam logic [31:0] VERTEX_VALUE_LUKEWARM_U32 = 32'h0000_0033;
endpackage

module vertex_criterion_demux_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 32,
  parameter int NUM_REQ    = 4,
  parameter int BUS_WIDTH  = 4,
  parameter int CREDITS    = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enabled,
  input  logic [0:NUM_REQ-1]                  req_valid,
  input  logic [NUM_REQ-1:0][SEL_WIDTH-1:0]   req_sel,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  output logic [0:NUM_REQ-1]                  req_ready,
  input  logic [0:BUS_WIDTH-1]                credit_return,
  output logic [SEL_WIDTH-1:0]                sel_out,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                data_out_valid,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id,
  output logic                                drained,
  output logic                                credit_error
);
  import globals_cu_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int BW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt [BUS_WIDTH];
  logic [NUM_REQ-1:0] elig;
  logic [0:BUS_WIDTH-1] dec_v;
  logic [IW-1:0] ptr, gnt;
  logic [BW-1:0] gnt_bus;
  logic found, fire, all_full;

  function automatic logic [BW-1:0] bus_of(input logic [SEL_WIDTH-1:0] s);
    if (s == SEL_WIDTH'(VERTEX_VALUE_HOT_U32))      return BW'(3);
    if (s == SEL_WIDTH'(VERTEX_CACHE_WARM_U32))     return BW'(1);
    if (s == SEL_WIDTH'(VERTEX_VALUE_LUKEWARM_U32)) return BW'(2);
    return BW'(0);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] && (cnt[bus_of(req_sel[i])] != '0);
  end

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = IW'(idx);
      end
    end
  end

  assign fire    = (state == RUN) && found;
  assign gnt_bus = bus_of(req_sel[gnt]);
  assign drained = (state == IDLE);

  always_comb begin
    req_ready = '0;
    if (fire) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    all_full = 1'b1;
    for (int b = 0; b < BUS_WIDTH; b++) begin
      dec_v[b] = fire && (gnt_bus == BW'(b));
      if (cnt[b] != CW'(CREDITS)) all_full = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enabled) state_nx = RUN;
      RUN:     if (!enabled) state_nx = DRAIN;
      DRAIN:   if (enabled) state_nx = RUN;
               else if (all_full) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // A return against a full counter is dropped and flagged.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < BUS_WIDTH; b++) cnt[b] <= CW'(CREDITS);
      credit_error <= 1'b0;
    end else begin
      for (int b = 0; b < BUS_WIDTH; b++) begin
        if (dec_v[b] && !credit_return[b])
          cnt[b] <= cnt[b] - CW'(1);
        else if (!dec_v[b] && credit_return[b]) begin
          if (cnt[b] == CW'(CREDITS)) credit_error <= 1'b1;
          else                        cnt[b] <= cnt[b] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr            <= '0;
      data_out_valid <= 1'b0;
      sel_out        <= '0;
      data_out       <= '0;
      grant_id       <= '0;
    end else begin
      data_out_valid <= fire;
      if (fire) begin
        sel_out  <= req_sel[gnt];
        data_out <= req_data[gnt];
        grant_id <= gnt;
        ptr      <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_vertex_criterion_demux_arbiter.sv
// Bench for vertex_criterion_demux_arbiter: reference model plus scoreboard.
// Directed scenarios followed by a randomized run with occasional resets.
module tb_vertex_criterion_demux_arbiter;
  import globals_cu_pkg::*;

  localparam int DW = 32;
  localparam int SW = 32;
  localparam int NR = 4;
  localparam int NB = 4;
  localparam int CR = 8;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;

  logic clock = 1'b0;
  logic reset, enabled;
  logic [0:NR-1] req_valid, req_ready;
  logic [NR-1:0][SW-1:0] req_sel;
  logic [NR-1:0][DW-1:0] req_data;
  logic [0:NB-1] credit_return;
  logic [SW-1:0] sel_out;
  logic [DW-1:0] data_out;
  logic data_out_valid;
  logic [1:0] grant_id;
  logic drained, credit_error;

  vertex_criterion_demux_arbiter #(
    .DATA_WIDTH(DW), .SEL_WIDTH(SW), .NUM_REQ(NR),
    .BUS_WIDTH(NB), .CREDITS(CR)
  ) dut (
    .clock(clock), .reset(reset), .enabled(enabled),
    .req_valid(req_valid), .req_sel(req_sel), .req_data(req_data),
    .req_ready(req_ready), .credit_return(credit_return),
    .sel_out(sel_out), .data_out(data_out),
    .data_out_valid(data_out_valid), .grant_id(grant_id),
    .drained(drained), .credit_error(credit_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    int id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_cred[NB];
  int m_p, m_state, xfers;
  int gcount[NR];
  bit m_err;
  bit mon_on = 0;
  logic [SW-1:0] last_sel;
  logic [DW-1:0] last_data;
  int last_id;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bus_of(logic [SW-1:0] s);
    case (s)
      VERTEX_VALUE_HOT_U32:      return 3;
      VERTEX_CACHE_WARM_U32:     return 1;
      VERTEX_VALUE_LUKEWARM_U32: return 2;
      default:                   return 0;
    endcase
  endfunction

  function automatic int pick();
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_p + k) % NR;
      if (req_valid[i] && m_cred[bus_of(req_sel[i])] > 0) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    foreach (m_cred[b]) m_cred[b] = CR;
    m_p = 0;
    m_state = S_IDLE;
    m_err = 0;
    sb.delete();
    last_sel = '0;
    last_data = '0;
    last_id = 0;
  endtask

  // One clock: check combinational outputs, then advance the model.
  task automatic step();
    int g;
    bit full;
    logic [0:NR-1] er;
    #1;
    g = (m_state == S_RUN) ? pick() : -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("drained", 64'(drained), 64'(m_state == S_IDLE));
    chk("credit_error", 64'(credit_error), 64'(m_err));
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      full = 1;
      foreach (m_cred[b]) if (m_cred[b] != CR) full = 0;
      case (m_state)
        S_IDLE:  if (enabled) m_state = S_RUN;
        S_RUN:   if (!enabled) m_state = S_DRAIN;
        default: if (enabled) m_state = S_RUN;
                 else if (full) m_state = S_IDLE;
      endcase
      if (g >= 0) begin
        sb.push_back('{req_sel[g], req_data[g], g});
        m_p = (g + 1) % NR;
        m_cred[bus_of(req_sel[g])] -= 1;
        xfers++;
        gcount[g]++;
      end
      for (int b = 0; b < NB; b++) begin
        if (credit_return[b]) m_cred[b] += 1;
        if (m_cred[b] > CR) begin
          m_cred[b] = CR;
          m_err = 1;
        end
      end
    end
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_valid", 64'(data_out_valid), 64'd1);
        chk("sel_out", 64'(sel_out), 64'(e.sel));
        chk("data_out", 64'(data_out), 64'(e.data));
        chk("grant_id", 64'(grant_id), 64'(e.id));
        last_sel = e.sel;
        last_data = e.data;
        last_id = e.id;
      end else begin
        chk("out_idle", 64'(data_out_valid), 64'd0);
        chk("sel_hold", 64'(sel_out), 64'(last_sel));
        chk("data_hold", 64'(data_out), 64'(last_data));
        chk("id_hold", 64'(grant_id), 64'(last_id));
      end
    end
  end

  task automatic quiet();
    enabled = 0;
    req_valid = '0;
    credit_return = '0;
    for (int i = 0; i < NR; i++) begin
      req_sel[i] = '0;
      req_data[i] = '0;
    end
  endtask

  task automatic do_reset();
    quiet();
    reset = 1;
    step();
    reset = 0;
  endtask

  function automatic logic [SW-1:0] rand_sel();
    case ($urandom_range(0, 3))
      0:       return VERTEX_VALUE_HOT_U32;
      1:       return VERTEX_CACHE_WARM_U32;
      2:       return VERTEX_VALUE_LUKEWARM_U32;
      default: return SW'($urandom());
    endcase
  endfunction

  initial begin
    int x0, g0, g1;
    quiet();
    reset = 1;
    xfers = 0;
    foreach (gcount[i]) gcount[i] = 0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    mon_on = 1;
    reset = 0;
    chk("reset_drained", 64'(drained), 64'd1);
    chk("reset_valid", 64'(data_out_valid), 64'd0);

    // Hot traffic from all requesters, credits looped back from the output.
    do_reset();
    enabled = 1;
    x0 = xfers;
    for (int c = 0; c < 14; c++) begin
      req_valid = '1;
      for (int i = 0; i < NR; i++) begin
        req_sel[i] = VERTEX_VALUE_HOT_U32;
        req_data[i] = $urandom();
      end
      credit_return = '0;
      credit_return[3] = data_out_valid;
      step();
    end
    chk("hot_xfers", 64'(xfers - x0), 64'd13);

    // Single warm requester exhausts bus 1, then one credit comes back.
    do_reset();
    enabled = 1;
    req_valid[2] = 1;
    req_sel[2] = VERTEX_CACHE_WARM_U32;
    x0 = xfers;
    for (int c = 0; c < 14; c++) begin
      req_data[2] = $urandom();
      step();
    end
    chk("warm_exhaust", 64'(xfers - x0), 64'd8);
    credit_return[1] = 1;
    step();
    credit_return[1] = 0;
    for (int c = 0; c < 4; c++) step();
    chk("warm_refill", 64'(xfers - x0), 64'd9);

    // Starved hot requester must not block a default-bus requester.
    do_reset();
    enabled = 1;
    req_valid[0] = 1;
    req_sel[0] = VERTEX_VALUE_HOT_U32;
    for (int c = 0; c < 10; c++) step();
    req_valid[1] = 1;
    req_sel[1] = 32'hDEAD;
    g0 = gcount[0];
    g1 = gcount[1];
    for (int c = 0; c < 8; c++) begin
      req_data[1] = $urandom();
      step();
    end
    chk("starved_r0", 64'(gcount[0] - g0), 64'd0);
    chk("served_r1", 64'(gcount[1] - g1), 64'd8);

    // Drain with three lukewarm credits outstanding.
    do_reset();
    enabled = 1;
    req_valid[2] = 1;
    req_sel[2] = VERTEX_VALUE_LUKEWARM_U32;
    for (int c = 0; c < 4; c++) step();
    req_valid = '0;
    enabled = 0;
    for (int c = 0; c < 3; c++) step();
    chk("drain_busy", 64'(drained), 64'd0);
    for (int c = 0; c < 3; c++) begin
      credit_return[2] = 1;
      step();
    end
    credit_return[2] = 0;
    for (int c = 0; c < 3; c++) step();
    chk("drain_done", 64'(drained), 64'd1);

    // Overflow flag, then reset in the middle of a transfer.
    do_reset();
    credit_return[0] = 1;
    step();
    credit_return[0] = 0;
    step();
    chk("overflow_flag", 64'(credit_error), 64'd1);
    enabled = 1;
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_sel[i] = VERTEX_VALUE_HOT_U32;
    step();
    reset = 1;
    step();
    reset = 0;
    chk("rst_flush", 64'(data_out_valid), 64'd0);
    chk("rst_err", 64'(credit_error), 64'd0);
    enabled = 0;
    req_valid = '0;
    step();
    step();
    chk("rst_credits_full", 64'(drained), 64'd1);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      enabled = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = $urandom_range(0, 1);
        req_sel[i] = rand_sel();
        req_data[i] = $urandom();
      end
      for (int b = 0; b < NB; b++)
        credit_return[b] = ($urandom_range(0, 3) == 0);
      step();
    end
    reset = 0;
    quiet();
    step();
    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
